// File: rtl/nibble_feeder_pkg.sv
// Shared constants for the nibble feeder.
//   NIB_W         - width of one nibble
//   DEFAULT_DEPTH - default FIFO depth in nibbles
//   SENT_CNT_W    - width of the popped-nibble counter
package nibble_feeder_pkg;

    localparam int unsigned NIB_W         = 4;
    localparam int unsigned DEFAULT_DEPTH = 8;
    localparam int unsigned SENT_CNT_W    = 8;

endpackage

// File: rtl/nibble_fifo.sv
// Nibble FIFO: storage, wrapping read/write pointers and occupancy level.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset (pointers and level only)
//   wr_en    - write request; ignored when full
//   wr_data  - nibble written at the tail
//   rd_en    - read request; ignored when empty
//   rd_data  - head entry (valid only when not empty)
//   level    - current occupancy
//   full     - level == DEPTH
//   empty    - level == 0
module nibble_fifo
    import nibble_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [NIB_W-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [NIB_W-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [NIB_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             wr_ok, rd_ok;

    // Full/empty come from the level, so equal pointers are never ambiguous.
    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
        wr_ptr_d = wr_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; nothing outside reads it while empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/nibble_feeder.sv
// Nibble feeder: buffers host nibbles and presents them to a
// parallel-to-serial converter, one pop per ack.
// Ports:
//   sclk      - sole clock, rising edge
//   rst       - synchronous active-high reset
//   in_data   - nibble from the host
//   in_valid  - host has in_data available
//   in_ready  - feeder can accept a nibble (FIFO not full)
//   ack       - converter consumed the current data at this edge
//   data      - nibble presented to the converter
//   clr       - clears underrun and sent_cnt
//   level     - FIFO occupancy
//   underrun  - sticky: ack seen while FIFO empty
//   sent_cnt  - nibbles popped, modulo 256
module nibble_feeder
    import nibble_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     sclk,
    input  logic                     rst,
    input  logic [NIB_W-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     ack,
    output logic [NIB_W-1:0]         data,
    input  logic                     clr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic [SENT_CNT_W-1:0]    sent_cnt
);

    logic                  full, empty;
    logic                  push, pop;
    logic [NIB_W-1:0]      head;
    logic [NIB_W-1:0]      hold_q, hold_d;
    logic                  underrun_q, underrun_d;
    logic [SENT_CNT_W-1:0] sent_cnt_q, sent_cnt_d;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // Pop is qualified by the level before the edge, so a push into an
    // empty FIFO cannot be popped at the same edge.
    assign pop      = ack && !empty;

    nibble_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sclk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // Only registered state feeds data, so it moves at clock edges only.
    assign data     = empty ? hold_q : head;
    assign underrun = underrun_q;
    assign sent_cnt = sent_cnt_q;

    always_comb begin
        hold_d     = hold_q;
        underrun_d = underrun_q;
        sent_cnt_d = sent_cnt_q;
        if (pop) begin
            hold_d = head;
        end
        if (clr) begin
            underrun_d = 1'b0;
            sent_cnt_d = '0;
        end else begin
            if (ack && empty) begin
                underrun_d = 1'b1;
            end
            if (pop) begin
                sent_cnt_d = sent_cnt_q + SENT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            hold_q     <= '0;
            underrun_q <= 1'b0;
            sent_cnt_q <= '0;
        end else begin
            hold_q     <= hold_d;
            underrun_q <= underrun_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

endmodule

// File: doc/nibble_feeder.md
NIBBLE_FEEDER -- requirements
Module: nibble_feeder

Interface
REQ-001 Parameter DEPTH, default 8; FIFO depth in nibbles, power of two, range 2..16.
REQ-002 sclk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_data  input  4  nibble from the host.
REQ-005 in_valid  input  1  host has in_data available.
REQ-006 in_ready  output  1  feeder can accept a nibble; asserted when the FIFO is not full.
REQ-007 ack  input  1  from the parallel-to-serial converter; high at an sclk edge means the current data has been consumed.
REQ-008 data  output  4  nibble presented to the converter's data input.
REQ-009 clr  input  1  clears underrun and sent_cnt.
REQ-010 level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-011 underrun  output  1  sticky flag: ack arrived while the FIFO was empty.
REQ-012 sent_cnt  output  8  count of nibbles popped; wraps modulo 256.

Function
REQ-013 A push occurs at an edge where in_valid=1 and in_ready=1; in_data is written at the tail.
REQ-014 in_ready shall be 1 exactly when level<DEPTH, evaluated combinationally from registered level.
REQ-015 A pop occurs at an edge where ack=1 and level>0 before that edge; the head entry is removed.
REQ-016 data shall equal the head entry when level>0; when level=0 it shall hold the last popped value (0 after reset).
REQ-017 data shall change only at a clock edge, never combinationally from ack or in_data.
REQ-018 Push and pop at the same edge: level is unchanged, both operations take effect.
REQ-019 When full, push is refused even if a pop occurs at the same edge; in_ready stays 0 for that cycle.
REQ-020 When level=0, ack=1 and push happen at the same edge: no pop occurs, underrun sets, level becomes 1, and data shows the new entry from the next cycle.
REQ-021 ack=1 with level=0 sets underrun; it stays set until clr or rst; the data output stays at its held value.
REQ-022 Each pop increments sent_cnt by 1; 255 wraps to 0.
REQ-023 clr=1 zeroes underrun and sent_cnt at that edge; clr has priority over a simultaneous set or increment; FIFO contents are unaffected.
REQ-024 Read and write pointers are DEPTH-modulo with wrap; full/empty are derived from level, not from pointer equality alone.
REQ-025 ack held high across consecutive cycles pops one entry per edge while level>0.

Reset
REQ-026 At rst=1 edge: level=0, pointers=0, data=0, underrun=0, sent_cnt=0, in_ready=1 from the next cycle.
REQ-027 rst mid-operation discards all stored nibbles; rst has priority over push, pop and clr.
REQ-028 FIFO storage RAM need not be reset; no output may expose stale storage after reset.

Structure
REQ-029 Shared package holds NIB_W=4, DEFAULT_DEPTH=8, SENT_CNT_W=8.
REQ-030 Storage, pointers and level are implemented in a sub-module nibble_fifo; nibble_feeder adds the hold register, underrun and sent_cnt.
REQ-031 nibble_feeder drops in between the host and the converter's data/ack ports with no glue logic.

Verification
REQ-032 Reset, then push 3,5,A -> level=3, data=3; ack pulse for 1 cycle -> data=5, sent_cnt=1.
REQ-033 Push 8 nibbles with ack=0 -> level=8, in_ready=0; 9th in_valid is refused; ack for 1 cycle with in_valid=1 -> level=7, no push.
REQ-034 Empty FIFO, ack=1 -> underrun=1, data holds last value; clr -> underrun=0, sent_cnt=0.
REQ-035 level=0 with push of C and ack at the same edge -> underrun=1, level=1, data=C next cycle.
REQ-036 Stream 300 nibbles with ack every 4th cycle -> data sequence matches input order, sent_cnt=44 (300 mod 256), pointers wrap correctly.
REQ-037 rst asserted with level=5 -> next cycle level=0, data=0, in_ready=1, counters zero.
